stack_unit: RTL
===============

Name: stack_unit

Overview:
- Hardware operand stack for the 16-bit stack processor.
- Sits directly downstream of the 8:1 data-select mux. The mux output drives din, and the mux control field selects the value to be pushed or written.
- Exposes top-of-stack (TOS) and next-on-stack (NOS) combinationally to the ALU and to the mux inputs.
- Executes one stack operation per clock.

Parameters:
- WIDTH, 16, data word width.
- DEPTH, 16, number of stack entries; must be a power of 2, minimum 4.
- CNT_W, 5, width of the occupancy count; equals log2(DEPTH)+1.

Ports:
- clk  input  1  system clock, rising-edge.
- reset_n  input  1  asynchronous, active-low reset.
- din  input  WIDTH  data from the mux output.
- op  input  3  operation code: 000 NOP, 001 PUSH, 010 POP, 011 REPL, 100 POPREPL, 101 SWAP, 110/111 NOP.
- tos  output  WIDTH  top-of-stack entry.
- nos  output  WIDTH  entry directly below the top.
- count  output  CNT_W  number of valid entries, 0..DEPTH.
- empty  output  1  count==0.
- full  output  1  count==DEPTH.
- err_ovf  output  1  sticky overflow flag.
- err_unf  output  1  sticky underflow flag.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- While reset_n=0:
  - count=0, err_ovf=0, err_unf=0.
  - Storage array is not cleared.
  - Outputs therefore read tos=0, nos=0, empty=1, full=0.
- Deasserting reset_n mid-operation discards any in-flight op. The first op is sampled at the first rising edge with reset_n=1.
- Storage: array mem[0..DEPTH-1]. mem[count-1] is TOS and mem[count-2] is NOS.
- Output gating:
  - tos = mem[count-1] when count>=1, else 0.
  - nos = mem[count-2] when count>=2, else 0.
  - tos, nos, empty and full are combinational from the registered count and array; there is no extra output register.
- Latency: an op sampled on rising edge N is reflected on tos/nos/count immediately after edge N. It is visible to the consumer in cycle N+1.
- Operations, each committed at the rising edge:
  - PUSH: requires count<DEPTH. mem[count]<=din, count<=count+1.
  - POP: requires count>=1. count<=count-1; data is left in place.
  - REPL: requires count>=1. mem[count-1]<=din; count unchanged. Used for unary ALU results.
  - POPREPL: requires count>=2. mem[count-2]<=din, count<=count-1. Used for binary ALU results.
  - SWAP: requires count>=2. mem[count-1]<=old NOS and mem[count-2]<=old TOS in the same edge.
  - NOP and reserved codes: no state change.
- Error handling:
  - Precondition failure: the op is suppressed entirely, with no array write and no count change.
  - PUSH when full sets err_ovf.
  - POP, REPL, POPREPL or SWAP with too few entries sets err_unf.
  - Flags are sticky until reset; there is no software clear.
  - Flags may both be set; each one sets independently.
- Count arithmetic is CNT_W-bit unsigned. It never wraps, because suppression prevents 0-1 and DEPTH+1.
- Rotating PUSH/POP through all DEPTH entries must reach index DEPTH-1 and back to 0 without aliasing.
- Only one op exists per cycle, so there are no simultaneous-event conflicts. Read-before-write holds within an edge: all ops use pre-edge count and pre-edge data.
- din is sampled only for PUSH, REPL and POPREPL. X on din during other ops must not propagate.

Test Plan:
- Reset then idle: assert reset_n=0 asynchronously mid-cycle -> count=0, empty=1, tos=0, nos=0, both err flags=0 immediately, without waiting for a clock edge.
- PUSH 0x0003 then PUSH 0x0005 -> after edge 1: tos=3, count=1, nos=0. After edge 2: tos=5, nos=3, count=2.
- SWAP, then POPREPL with din=0x0008 from that state -> after SWAP: tos=3, nos=5. After POPREPL: tos=8, count=1, nos=0.
- REPL din=0x1234 on count=1, then POP twice -> after REPL: tos=0x1234. After first POP: count=0, empty=1. Second POP: count stays 0, err_unf=1 and remains 1 through 10 further NOPs.
- PUSH values 1..16 -> full=1, tos=16, nos=15. 17th PUSH din=0xFFFF -> tos stays 16, count=16, err_ovf=1. Then POP 16 times -> values return in order 16..1, ending empty=1.
- Reset mid-sequence: count=7 with err_ovf=1, pulse reset_n low for 3 ns -> count=0 and err_ovf=0 at once. The next PUSH 0x00AA yields tos=0xAA, count=1.

Source files
------------

// File: rtl/stack_unit.sv
// Operand stack for the 16-bit stack processor: one push/pop/replace/swap per clock,
// with TOS/NOS exposed combinationally and sticky overflow/underflow flags.
module stack_unit #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] din,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] tos,
  output logic [WIDTH-1:0] nos,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full,
  output logic             err_ovf,
  output logic             err_unf
);
  localparam int AW = $clog2(DEPTH);

  localparam logic [2:0] OP_PUSH    = 3'b001;
  localparam logic [2:0] OP_POP     = 3'b010;
  localparam logic [2:0] OP_REPL    = 3'b011;
  localparam logic [2:0] OP_POPREPL = 3'b100;
  localparam logic [2:0] OP_SWAP    = 3'b101;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    push_idx, top_idx, nos_idx;
  logic             has1, has2;
  logic             do_push, do_pop, do_repl, do_poprepl, do_swap;
  logic             ovf_hit, unf_hit;
  logic [CNT_W-1:0] count_nxt;

  // Low AW bits of count address the next free slot; at count==DEPTH they
  // wrap to 0 so top_idx still lands on DEPTH-1.
  assign push_idx = count[AW-1:0];
  assign top_idx  = push_idx - AW'(1);
  assign nos_idx  = push_idx - AW'(2);

  assign has1  = (count != '0);
  assign has2  = (count >= CNT_W'(2));
  assign empty = ~has1;
  assign full  = (count == CNT_W'(DEPTH));
  assign tos   = has1 ? mem[top_idx] : '0;
  assign nos   = has2 ? mem[nos_idx] : '0;

  always_comb begin
    do_push    = 1'b0;
    do_pop     = 1'b0;
    do_repl    = 1'b0;
    do_poprepl = 1'b0;
    do_swap    = 1'b0;
    ovf_hit    = 1'b0;
    unf_hit    = 1'b0;
    count_nxt  = count;
    case (op)
      OP_PUSH: begin
        do_push = ~full;
        ovf_hit = full;
        if (do_push) count_nxt = count + CNT_W'(1);
      end
      OP_POP: begin
        do_pop  = has1;
        unf_hit = ~has1;
        if (do_pop) count_nxt = count - CNT_W'(1);
      end
      OP_REPL: begin
        do_repl = has1;
        unf_hit = ~has1;
      end
      OP_POPREPL: begin
        do_poprepl = has2;
        unf_hit    = ~has2;
        if (do_poprepl) count_nxt = count - CNT_W'(1);
      end
      OP_SWAP: begin
        do_swap = has2;
        unf_hit = ~has2;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count   <= '0;
      err_ovf <= 1'b0;
      err_unf <= 1'b0;
    end else begin
      count <= count_nxt;
      if (ovf_hit) err_ovf <= 1'b1;
      if (unf_hit) err_unf <= 1'b1;
    end
  end

  // Storage is deliberately left out of reset; output gating hides stale entries.
  always_ff @(posedge clk) begin
    if (do_push)    mem[push_idx] <= din;
    if (do_repl)    mem[top_idx]  <= din;
    if (do_poprepl) mem[nos_idx]  <= din;
    if (do_swap) begin
      mem[top_idx] <= mem[nos_idx];
      mem[nos_idx] <= mem[top_idx];
    end
  end
endmodule
